// File: rtl/switch_pkg.sv
// Shared definitions for the switch debounce bank: mode encodings and
// the sizing helper for the per-channel stability counter.
package switch_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_INVERT = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    // Counter must represent 0 .. DB_CYC-1 plus headroom up to DB_CYC.
    function automatic int cnt_width(input int db_cyc);
        return $clog2(db_cyc + 1);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One switch channel: two-flop synchronizer followed by a stability counter
// that only lets the debounced level move after DB_CYC consecutive disagreements.
module debounce_cell
    import switch_pkg::*;
#(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam int CW = cnt_width(DB_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/switch_debounce_bank.sv
// Bank of N debounced switches with a mode-selected output conditioner
// (pass, invert, hold, toggle-on-press) and a registered change pulse.
module switch_debounce_bank
    import switch_pkg::*;
#(
    parameter int N      = 8,
    parameter int OUT_W  = 10,
    parameter int DB_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     sw_in,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] x,
    output logic             changed
);

    logic [N-1:0] db;
    logic [N-1:0] db_q;
    logic [N-1:0] rise;
    logic [N-1:0] x_low;
    logic [N-1:0] x_nxt;
    logic         pend;
    mode_e        mode_s;

    for (genvar i = 0; i < N; i++) begin : g_cell
        debounce_cell #(
            .DB_CYC(DB_CYC)
        ) u_cell (
            .clk(clk),
            .rst(rst),
            .raw(sw_in[i]),
            .db (db[i])
        );
    end

    assign mode_s = mode_e'(mode);
    assign rise   = db & ~db_q;

    always_comb begin
        x_nxt = x_low;
        case (mode_s)
            MODE_PASS:   x_nxt = db;
            MODE_INVERT: x_nxt = ~db;
            MODE_HOLD:   x_nxt = x_low;
            MODE_TOGGLE: x_nxt = x_low ^ rise;
        endcase
    end

    // pend marks the edge where x took a new value; changed follows one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_low   <= '0;
            db_q    <= '0;
            pend    <= 1'b0;
            changed <= 1'b0;
        end else begin
            x_low   <= x_nxt;
            db_q    <= db;
            pend    <= (x_nxt != x_low);
            changed <= pend;
        end
    end

    if (OUT_W > N) begin : g_pad
        assign x = {{(OUT_W - N){1'b0}}, x_low};
    end else begin : g_nopad
        assign x = x_low;
    end

endmodule

// File: tb/tb_switch_debounce_bank.sv
// Self-checking bench for switch_debounce_bank: cycle scoreboard plus
// directed latency and pulse-count checks for each operating mode.
module tb_switch_debounce_bank;
    import switch_pkg::*;

    localparam int N      = 8;
    localparam int OUT_W  = 10;
    localparam int DB_CYC = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     sw_in = '0;
    logic [1:0]       mode = 2'b00;
    logic [OUT_W-1:0] x;
    logic             changed;

    always #5 clk = ~clk;

    switch_debounce_bank #(
        .N(N), .OUT_W(OUT_W), .DB_CYC(DB_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_in(sw_in),
        .mode(mode),
        .x(x),
        .changed(changed)
    );

    int vectors     = 0;
    int miscompares = 0;
    int chg_count   = 0;

    logic [OUT_W:0] exp_q[$];

    // reference state
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_dbq = '0, m_x = '0;
    logic         m_pend = 1'b0, m_chg = 1'b0;
    logic [N-1:0] m_hist [DB_CYC];
    int           m_valid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Debounced level flips once the last DB_CYC synchronized samples all disagree with it.
    task automatic model_edge(input logic r, input logic [N-1:0] s, input logic [1:0] md);
        logic [N-1:0] x_new;
        logic [N-1:0] flip;
        logic         agree;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_dbq = '0; m_x = '0;
            m_pend = 1'b0; m_chg = 1'b0; m_valid = 0;
        end else begin
            for (int k = DB_CYC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_s2;
            if (m_valid < DB_CYC) m_valid++;
            flip = '0;
            if (m_valid >= DB_CYC) begin
                for (int i = 0; i < N; i++) begin
                    agree = 1'b1;
                    for (int k = 0; k < DB_CYC; k++)
                        if (m_hist[k][i] == m_db[i]) agree = 1'b0;
                    flip[i] = agree;
                end
            end
            case (md)
                2'b00:   x_new = m_db;
                2'b01:   x_new = ~m_db;
                2'b10:   x_new = m_x;
                default: x_new = m_x ^ (m_db & ~m_dbq);
            endcase
            m_chg  = m_pend;
            m_pend = (x_new != m_x);
            m_x    = x_new;
            m_dbq  = m_db;
            m_db   = m_db ^ flip;
            m_s2   = m_s1;
            m_s1   = s;
        end
        exp_q.push_back({m_chg, {(OUT_W - N){1'b0}}, m_x});
    endtask

    task automatic step(input logic r, input logic [N-1:0] s, input logic [1:0] md);
        logic [OUT_W:0] e;
        rst   = r;
        sw_in = s;
        mode  = md;
        model_edge(r, s, md);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("x", 32'(x), 32'(e[OUT_W-1:0]));
            check("changed", 32'(changed), 32'(e[OUT_W]));
            check("pad", 32'(x[OUT_W-1:N]), 32'd0);
        end
        chg_count += int'(changed);
    endtask

    initial begin
        int lat;
        logic [N-1:0] v;
        logic [1:0]   md;
        int len;
        for (int k = 0; k < DB_CYC; k++) m_hist[k] = '0;

        // PASS latency from reset
        repeat (3) step(1'b1, 8'h00, MODE_PASS);
        check("rst_x", 32'(x), 32'd0);
        check("rst_chg", 32'(changed), 32'd0);
        repeat (3) step(1'b0, 8'h00, MODE_PASS);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 8'hA5, MODE_PASS);
            if (k == 5) check("pass_early", 32'(x), 32'h000);
            if (k == 6) begin
                check("pass_lat", 32'(x), 32'h0A5);
                check("pass_chg0", 32'(changed), 32'd0);
            end
            if (k == 7) check("pass_chg1", 32'(changed), 32'd1);
        end

        // short glitch rejected
        repeat (2) step(1'b1, 8'h00, MODE_PASS);
        chg_count = 0;
        repeat (3) step(1'b0, 8'h01, MODE_PASS);
        repeat (10) step(1'b0, 8'h00, MODE_PASS);
        check("glitch_x", 32'(x), 32'h000);
        check("glitch_chg", 32'(chg_count), 32'd0);

        // INVERT out of reset
        repeat (2) step(1'b1, 8'h0F, MODE_INVERT);
        step(1'b0, 8'h0F, MODE_INVERT);
        check("inv_first", 32'(x), 32'h0FF);
        for (int k = 1; k < 9; k++) begin
            step(1'b0, 8'h0F, MODE_INVERT);
            if (k == 1) check("inv_chg", 32'(changed), 32'd1);
            if (k == 6) check("inv_db", 32'(x), 32'h0F0);
        end

        // TOGGLE: presses flip, releases do nothing
        repeat (2) step(1'b1, 8'h00, MODE_TOGGLE);
        repeat (3) step(1'b0, 8'h00, MODE_TOGGLE);
        chg_count = 0;
        repeat (10) step(1'b0, 8'h08, MODE_TOGGLE);
        check("tog_press1", 32'(x), 32'h008);
        repeat (10) step(1'b0, 8'h00, MODE_TOGGLE);
        check("tog_rel1", 32'(x), 32'h008);
        repeat (10) step(1'b0, 8'h08, MODE_TOGGLE);
        check("tog_press2", 32'(x), 32'h000);
        repeat (10) step(1'b0, 8'h00, MODE_TOGGLE);
        check("tog_rel2", 32'(x), 32'h000);
        check("tog_pulses", 32'(chg_count), 32'd2);

        // HOLD then release to PASS
        repeat (2) step(1'b1, 8'h00, MODE_PASS);
        repeat (8) step(1'b0, 8'h55, MODE_PASS);
        check("hold_pre", 32'(x), 32'h055);
        repeat (10) step(1'b0, 8'hFF, MODE_HOLD);
        check("hold_x", 32'(x), 32'h055);
        chg_count = 0;
        step(1'b0, 8'hFF, MODE_PASS);
        check("hold_exit", 32'(x), 32'h0FF);
        repeat (3) step(1'b0, 8'hFF, MODE_PASS);
        check("hold_pulses", 32'(chg_count), 32'd1);

        // reset mid-debounce discards the partial count
        repeat (2) step(1'b1, 8'h00, MODE_PASS);
        repeat (2) step(1'b0, 8'h00, MODE_PASS);
        repeat (3) step(1'b0, 8'h01, MODE_PASS);
        step(1'b1, 8'h01, MODE_PASS);
        check("mid_rst_x", 32'(x), 32'h000);
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 8'h01, MODE_PASS);
            if (x == 10'h001 && lat < 0) lat = k;
        end
        check("mid_rst_lat", 32'(lat), 32'd6);

        // random levels, random mode changes, occasional reset
        md = MODE_PASS;
        for (int t = 0; t < 70; t++) begin
            v   = N'($urandom);
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) md = 2'($urandom_range(0, 3));
                step(($urandom_range(0, 99) == 0), v, md);
            end
        end

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
